// File: rtl/fast_pkg.sv
// rtl/fast_pkg.sv - shared window geometry and pixel/window types for the FAST pipeline
package fast_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int WIN_SIZE    = 7;
  localparam int FAST_RADIUS = 3;
  localparam int N_CIRCLE    = 16;
  localparam int N_LINES     = WIN_SIZE - 1;

  typedef logic [DATA_WIDTH-1:0] pixel_t;
  typedef pixel_t [0:WIN_SIZE-1][0:WIN_SIZE-1] window_t;

endpackage

// File: rtl/fast_line_buffer.sv
// rtl/fast_line_buffer.sv - one-line delay memory, read-before-write on a shared address
module fast_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Asynchronous read returns the old word while the same address is written at the edge.
  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/fast_window_gen.sv
// rtl/fast_window_gen.sv - raster pixel stream to sliding 7x7 window with centre coordinates
module fast_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  localparam int XW        = $clog2(IMG_WIDTH),
  localparam int YW        = $clog2(IMG_HEIGHT)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pix_valid,
  input  logic                              pix_sof,
  input  logic [DATA_WIDTH-1:0]             pix_data,
  output logic                              window_valid,
  output logic [0:6][0:6][DATA_WIDTH-1:0]   window,
  output logic [XW-1:0]                     center_x,
  output logic [YW-1:0]                     center_y,
  output logic                              frame_done
);

  import fast_pkg::*;

  logic [XW-1:0]         x_cnt, eff_x;
  logic [YW-1:0]         y_cnt, eff_y;
  logic                  win_ok, last_x, last_y;
  logic [DATA_WIDTH-1:0] lb_din  [N_LINES];
  logic [DATA_WIDTH-1:0] lb_dout [N_LINES];
  logic [DATA_WIDTH-1:0] col     [WIN_SIZE];

  // A start-of-frame pixel is always (0,0), whatever the counters say.
  always_comb begin
    eff_x  = pix_sof ? '0 : x_cnt;
    eff_y  = pix_sof ? '0 : y_cnt;
    win_ok = (eff_x >= XW'(WIN_SIZE - 1)) && (eff_y >= YW'(WIN_SIZE - 1));
    last_x = (eff_x == XW'(IMG_WIDTH - 1));
    last_y = (eff_y == YW'(IMG_HEIGHT - 1));
  end

  always_comb begin
    col[0]    = pix_data;
    lb_din[0] = pix_data;
    for (int r = 1; r < WIN_SIZE; r++) begin
      col[r] = lb_dout[r-1];
    end
    for (int k = 1; k < N_LINES; k++) begin
      lb_din[k] = lb_dout[k-1];
    end
  end

  for (genvar k = 0; k < N_LINES; k++) begin : g_line
    fast_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH)
    ) u_line (
      .clk   (clk),
      .wr_en (pix_valid),
      .addr  (eff_x),
      .din   (lb_din[k]),
      .dout  (lb_dout[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt        <= '0;
      y_cnt        <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      window       <= '0;
      center_x     <= '0;
      center_y     <= '0;
    end else begin
      window_valid <= pix_valid & win_ok;
      frame_done   <= pix_valid & last_x & last_y;
      if (pix_valid) begin
        for (int r = 0; r < WIN_SIZE; r++) begin
          for (int c = 0; c < WIN_SIZE - 1; c++) begin
            window[r][c] <= window[r][c+1];
          end
          window[r][WIN_SIZE-1] <= col[r];
        end
        // Centre only moves with a valid window, so it always describes the presented one.
        if (win_ok) begin
          center_x <= eff_x - XW'(FAST_RADIUS);
          center_y <= eff_y - YW'(FAST_RADIUS);
        end
        if (last_x) begin
          x_cnt <= '0;
          y_cnt <= last_y ? '0 : eff_y + YW'(1);
        end else begin
          x_cnt <= eff_x + XW'(1);
          y_cnt <= eff_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_fast_window_gen.sv
// tb/tb_fast_window_gen.sv - self-checking bench for fast_window_gen against a frame-image model
module tb_fast_window_gen;

  localparam int DW = 8;
  localparam int W  = 16;
  localparam int H  = 8;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       pix_valid;
  logic                       pix_sof;
  logic [DW-1:0]              pix_data;
  logic                       window_valid;
  logic [0:6][0:6][DW-1:0]    window;
  logic [3:0]                 center_x;
  logic [2:0]                 center_y;
  logic                       frame_done;

  always #5 clk = ~clk;

  fast_window_gen #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .pix_data     (pix_data),
    .window_valid (window_valid),
    .window       (window),
    .center_x     (center_x),
    .center_y     (center_y),
    .frame_done   (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_win, cnt_fd;

  // Model: the image of the current frame as accepted so far, plus the expected outputs.
  logic [DW-1:0] img [0:H-1][0:W-1];
  logic [DW-1:0] exp_win [0:6][0:6];
  int  mx, my, exp_cx, exp_cy;
  bit  exp_v, exp_fd, known;

  typedef struct {
    string   name;
    int      r;
    int      c;
    int      exp;
  } win_vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0;
    exp_v = 0; exp_fd = 0;
    exp_cx = 0; exp_cy = 0;
    known = 1;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        exp_win[r][c] = '0;
  endtask

  task automatic model_accept(input bit v, input bit s, input logic [DW-1:0] d);
    int ex, ey;
    exp_v  = 0;
    exp_fd = 0;
    if (v) begin
      ex = s ? 0 : mx;
      ey = s ? 0 : my;
      img[ey][ex] = d;
      if (ex >= 6 && ey >= 6) begin
        exp_v = 1;
        known = 1;
        for (int r = 0; r < 7; r++)
          for (int c = 0; c < 7; c++)
            exp_win[r][c] = img[ey-r][ex-6+c];
        exp_cx = ex - 3;
        exp_cy = ey - 3;
      end else begin
        known = 0;
      end
      exp_fd = (ex == W-1) && (ey == H-1);
      mx = ex + 1;
      my = ey;
      if (mx == W) begin
        mx = 0;
        my = (ey + 1 == H) ? 0 : ey + 1;
      end
    end
  endtask

  task automatic compare_all();
    check("window_valid", int'(window_valid), int'(exp_v));
    check("frame_done", int'(frame_done), int'(exp_fd));
    if (window_valid) cnt_win++;
    if (frame_done) cnt_fd++;
    if (known) begin
      for (int r = 0; r < 7; r++)
        for (int c = 0; c < 7; c++)
          check($sformatf("window[%0d][%0d]", r, c), int'(window[r][c]), int'(exp_win[r][c]));
      check("center_x", int'(center_x), exp_cx);
      check("center_y", int'(center_y), exp_cy);
    end
  endtask

  task automatic step(input bit v, input bit s, input logic [DW-1:0] d);
    pix_valid = v;
    pix_sof   = s;
    pix_data  = d;
    @(posedge clk);
    model_accept(v, s, d);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input int base, input bit gaps, input bit use_sof);
    for (int i = 0; i < W*H; i++) begin
      while (gaps && $urandom_range(1, 0) == 1) step(1'b0, 1'b0, DW'($urandom));
      step(1'b1, use_sof && i == 0, DW'(base + i));
    end
  endtask

  win_vec_t first_win [7];

  initial begin
    first_win[0] = '{"first[0][6]", 0, 6, 'h66};
    first_win[1] = '{"first[6][0]", 6, 0, 'h00};
    first_win[2] = '{"first[3][3]", 3, 3, 'h33};
    first_win[3] = '{"first[0][3]", 0, 3, 'h63};
    first_win[4] = '{"first[0][0]", 0, 0, 'h60};
    first_win[5] = '{"first[6][6]", 6, 6, 'h06};
    first_win[6] = '{"first[3][6]", 3, 6, 'h36};

    rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    rst = 1'b0;

    // First window: table-driven checks right after pixel 0x66 is accepted.
    cnt_win = 0; cnt_fd = 0;
    for (int i = 0; i <= 'h66; i++) step(1'b1, i == 0, DW'(i));
    check("first_valid", int'(window_valid), 1);
    for (int k = 0; k < 7; k++)
      check(first_win[k].name, int'(window[first_win[k].r][first_win[k].c]), first_win[k].exp);
    check("first_cx", int'(center_x), 3);
    check("first_cy", int'(center_y), 3);

    // Rest of the frame, then one idle cycle to see frame_done settle.
    for (int i = 'h67; i < W*H; i++) step(1'b1, 1'b0, DW'(i));
    check("frame_done_last", int'(frame_done), 1);
    step(1'b0, 1'b0, 8'h00);
    check("full_windows", cnt_win, (W-6)*(H-6));
    check("full_frame_done", cnt_fd, 1);

    // Same frame with random gaps; counters already back at (0,0).
    cnt_win = 0; cnt_fd = 0;
    send_frame(0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    check("gap_windows", cnt_win, (W-6)*(H-6));
    check("gap_frame_done", cnt_fd, 1);

    // sof at (5,4): aborted frame produces no frame_done.
    cnt_win = 0; cnt_fd = 0;
    for (int i = 0; i < 4*W + 5; i++) step(1'b1, i == 0, DW'(i));
    check("abort_windows", cnt_win, 0);
    send_frame(0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    check("restart_windows", cnt_win, (W-6)*(H-6));
    check("restart_frame_done", cnt_fd, 1);

    // Back-to-back frames, second one offset by 0x80.
    send_frame(0, 1'b0, 1'b1);
    for (int i = 0; i <= 'h66; i++) step(1'b1, i == 0, DW'('h80 + i));
    check("b2b_valid", int'(window_valid), 1);
    check("b2b_center", int'(window[3][3]), 'hB3);
    check("b2b_newest", int'(window[0][6]), 'hE6);
    check("b2b_oldest", int'(window[6][0]), 'h80);
    for (int i = 'h67; i < W*H; i++) step(1'b1, 1'b0, DW'('h80 + i));

    // Asynchronous reset mid-stream, then resume from (0,0) without sof.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, DW'($urandom));
    step(1'b1, 1'b0, 8'h5A);
    #2;
    rst = 1'b1;
    pix_valid = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
    cnt_win = 0; cnt_fd = 0;
    send_frame('h20, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    check("post_reset_windows", cnt_win, (W-6)*(H-6));
    check("post_reset_frame_done", cnt_fd, 1);

    // Random data, random gaps, occasional sof.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(1, 0) == 1)
        step(1'b1, $urandom_range(149, 0) == 0, DW'($urandom));
      else
        step(1'b0, 1'b0, DW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fast_window_gen.md
Name: fast_window_gen

Overview:
Converts a raster-order pixel stream into a sliding 7x7 neighbourhood, one window per accepted pixel once enough context exists. It is the producer feeding the FAST-16 circle stage: it drives window_valid and window[0:6][0:6] with the layout that stage consumes. Internally it holds six line buffers and a 7x7 shift register, with column and row counters.

Parameters:
DATA_WIDTH, 8, pixel bit width
IMG_WIDTH, 640, pixels per line (>= 7)
IMG_HEIGHT, 480, lines per frame (>= 7)

Ports:
clk  input  1  single clock; all logic is rising-edge
rst  input  1  asynchronous, active-high reset
pix_valid  input  1  pixel accepted this cycle; no backpressure
pix_sof  input  1  qualified by pix_valid; this pixel is (0,0) of a new frame
pix_data  input  DATA_WIDTH  pixel value
window_valid  output  1  one-cycle strobe, window outputs are valid
window  output  DATA_WIDTH x [0:6][0:6]  row 0 = newest line (top), row 6 = oldest; col 6 = newest pixel, col 0 = oldest; centre at [3][3]
center_x  output  $clog2(IMG_WIDTH)  column of window[3][3]
center_y  output  $clog2(IMG_HEIGHT)  row of window[3][3]
frame_done  output  1  one-cycle pulse after the last pixel of a frame

Behaviour:
- Reset (async, rst=1): x/y counters = 0; window_valid = 0; frame_done = 0; all window entries, center_x and center_y = 0. Line buffer contents are not cleared. Stale data is harmless because validity is gated by the counters.
- Accept: on pix_valid=1, the pixel is at (x,y), where x and y are the current counter values. If pix_sof=1, it is treated as (0,0) regardless of the counters.
- Line buffers: line k (k=0..5) at address x reads the pixel from row y-1-k. This is read-before-write: the same cycle, line 0 is written with pix_data and line k with line k-1's old output.
- Column vector for the shift: col[0] = pix_data, col[r] = line r-1 output (r=1..6). On accept, window[r][c] <= window[r][c+1] for c = 0..5, and window[r][6] <= col[r]. Registered outputs.
- Validity: window_valid <= pix_valid & (x >= 6) & (y >= 6), evaluated with the effective (x,y).
  - Latency is 1 cycle from accepting pixel (x,y).
  - That window has center_x = x-3 and center_y = y-3.
  - Windows with x < 6 are suppressed, so no output ever mixes two lines.
- Per frame: exactly (IMG_WIDTH-6)*(IMG_HEIGHT-6) windows.
- Idle: when pix_valid=0, window, center_x and center_y hold their values; window_valid = 0; counters hold.
- Counter wrap:
  - x = IMG_WIDTH-1 -> x = 0, y++.
  - At (IMG_WIDTH-1, IMG_HEIGHT-1): x = y = 0, and frame_done = 1 on the next cycle.
  - Excess pixels without sof simply start a new frame at (0,0).
- pix_sof mid-frame: the counters restart and the aborted frame produces no frame_done. No window_valid occurs until the new frame's (6,6).
- pix_sof at x=0,y=0 is a no-op restart.
- Reset mid-frame: outputs clear immediately (asynchronously). The stream resumes cleanly from the next pix_sof or from the counters at (0,0).

Decomposition:
- Shared package fast_pkg:
  - constants WIN_SIZE=7, FAST_RADIUS=3, N_CIRCLE=16;
  - typedef pixel_t (logic [DATA_WIDTH-1:0]);
  - typedef window_t (pixel_t [0:6][0:6]).
  - Shared with the circle sampler and detector.
- One sub-module, fast_line_buffer:
  - IMG_WIDTH-deep, DATA_WIDTH-wide delay line with read-before-write on the same address;
  - instantiated 6 times;
  - maps to BRAM or distributed RAM.

Test Plan:
1. Reset: assert rst mid-stream -> window_valid=0, frame_done=0, all 49 window entries 0 asynchronously; no window output until (6,6) of the next frame.
2. First window (IMG_WIDTH=16, IMG_HEIGHT=8, pixel=y*16+x, continuous valid):
   - window_valid rises 1 cycle after pixel 0x66 is accepted;
   - window[0][6]=0x66, window[6][0]=0x00, window[3][3]=0x33, window[0][3]=0x63;
   - center_x=3, center_y=3.
3. Same image, full frame -> exactly 20 window_valid strobes, centres (3..12, 3..4); none with x<6; frame_done pulses once, 1 cycle after pixel 0x7F.
4. Random pix_valid gaps (~50% duty) -> the window and centre sequence is identical to test 2/3; outputs hold during gaps.
5. pix_sof asserted at pixel (5,4) -> counters restart at (0,0); no frame_done for the aborted frame; next window_valid occurs only after the new frame's (6,6), with correct contents.
6. Two back-to-back frames, no idle cycles, second frame values +0x80 -> the second frame's first window has window[3][3]=0xB3, with no contamination from frame 1 beyond rows already overwritten.
